// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan display.
//   DIGIT_W       width of one digit code
//   seg_t         7-bit segment vector, bit order g..a, active-low
//   SEG_*         active-low glyph constants
//   slot_state_t  per-slot scan state (anode-off gap, then drive)
package seg_pkg;

    localparam int DIGIT_W = 5;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'b1111111;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } slot_state_t;

endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: digit-source <-> display-driver bundle.
//   digits      flat 5-bit codes, digit i at [5*i+4:5*i], digit 0 leftmost
//   dp_mask     decimal-point enables
//   adj         adjust mode (enables blinking)
//   blink_mask  per-digit blink enables
//   seg/dp/an   active-low segment, decimal point and anode outputs
// master: the digit source; slave: the display driver.
interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4
);
    import seg_pkg::*;

    logic [DIGIT_W*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]         dp_mask;
    logic                          adj;
    logic [NUM_DIGITS-1:0]         blink_mask;
    seg_t                          seg;
    logic                          dp;
    logic [NUM_DIGITS-1:0]         an;

    modport master (
        output digits, dp_mask, adj, blink_mask,
        input  seg, dp, an
    );

    modport slave (
        input  digits, dp_mask, adj, blink_mask,
        output seg, dp, an
    );

endinterface

// File: rtl/seg_decode.sv
// seg_decode: combinational 5-bit digit code -> active-low seg_t glyph.
//   code  in  DIGIT_W  digit code
//   seg   out 7        segments g..a, active-low
// Codes 0-9 are decimal digits. Codes 10-15 render A,b,C,d,E,F only when
// SEG_SCAN_HEX_EN is defined, otherwise blank. Codes 16-31 are always blank.
module seg_decode
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] code,
    output seg_t               seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'd0:    seg = SEG_0;
            5'd1:    seg = SEG_1;
            5'd2:    seg = SEG_2;
            5'd3:    seg = SEG_3;
            5'd4:    seg = SEG_4;
            5'd5:    seg = SEG_5;
            5'd6:    seg = SEG_6;
            5'd7:    seg = SEG_7;
            5'd8:    seg = SEG_8;
            5'd9:    seg = SEG_9;
`ifdef SEG_SCAN_HEX_EN
            5'd10:   seg = SEG_A;
            5'd11:   seg = SEG_B;
            5'd12:   seg = SEG_C;
            5'd13:   seg = SEG_D;
            5'd14:   seg = SEG_E;
            5'd15:   seg = SEG_F;
`endif
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed seven-segment driver with an anode-off
// blanking gap at the start of every digit slot and per-digit blinking.
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   bus  slave seg_scan_display_if (digits, dp_mask, adj, blink_mask in;
//             seg, dp, an out, all outputs registered, active-low)
// Hex glyphs for codes 10-15 are enabled by defining SEG_SCAN_HEX_EN.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    seg_scan_display_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    slot_state_t           state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [BLK_W-1:0]      blk_cnt;
    logic                  phase;

    logic [DIGIT_W-1:0]    cur_code;
    seg_t                  cur_seg;
    logic                  cur_sup;
    logic [NUM_DIGITS-1:0] an_drive;

    // Live selection of the current digit; only captured on DRIVE entry,
    // so the seg/dp/an registers double as the per-slot holding registers.
    always_comb begin
        cur_code = bus.digits[int'(idx)*DIGIT_W +: DIGIT_W];
        cur_sup  = bus.adj & bus.blink_mask[idx] & ~phase;
        an_drive = '1;
        an_drive[idx] = cur_sup;
    end

    seg_decode u_decode (
        .code (cur_code),
        .seg  (cur_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_BLANK;
            cnt     <= '0;
            idx     <= '0;
            bus.seg <= SEG_BLANK;
            bus.dp  <= 1'b1;
            bus.an  <= '1;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                ST_BLANK: begin
                    if (cnt == CNT_PRE) begin
                        state   <= ST_DRIVE;
                        bus.seg <= cur_seg;
                        bus.dp  <= ~bus.dp_mask[idx];
                        bus.an  <= an_drive;
                    end
                end
                ST_DRIVE: begin
                    // seg/dp hold through the gap; only the anodes go off
                    if (cnt == CNT_LAST) begin
                        state  <= ST_BLANK;
                        bus.an <= '1;
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

    // Blink phase: held on while adj is low, toggles every BLINK_DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
            phase   <= 1'b1;
        end else if (!bus.adj) begin
            blk_cnt <= '0;
            phase   <= 1'b1;
        end else if (blk_cnt == BLK_LAST) begin
            blk_cnt <= '0;
            phase   <= ~phase;
        end else begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Testbench for seg_scan_display: NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2, BLINK_DIV=32. The stimulus issues one slot at a time and
// queues the expected slot contents; a monitor pops one entry per slot and
// checks every cycle of it. A separate checker watches anode hygiene.
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BD = 32;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         sup;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int tests = 0;
    int fails = 0;
    int ecnt;
    int slot_idx = 0;
    bit mon_en = 1'b0;
    rec_t q[$];
    rec_t cur;
    bit cur_valid = 1'b0;
    int hi_run = 0;
    logic [3:0] prev_an = 4'hF;

    always #5 clk = ~clk;

    seg_scan_display_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_display #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .BLINK_DIV    (BD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [4:0] code);
        case (code)
            5'd0: return 7'b1000000;
            5'd1: return 7'b1111001;
            5'd2: return 7'b0100100;
            5'd3: return 7'b0110000;
            5'd4: return 7'b0011001;
            5'd5: return 7'b0010010;
            5'd6: return 7'b0000010;
            5'd7: return 7'b1111000;
            5'd8: return 7'b0000000;
            5'd9: return 7'b0010000;
`ifdef SEG_SCAN_HEX_EN
            5'd10: return 7'b0001000;
            5'd11: return 7'b0000011;
            5'd12: return 7'b1000110;
            5'd13: return 7'b0100001;
            5'd14: return 7'b0000110;
            5'd15: return 7'b0001110;
`endif
            default: return 7'h7F;
        endcase
    endfunction

    // Rising edges since reset release; slot position = ecnt % RD
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        int p;
        if (mon_en) begin
            p = ecnt % RD;
            if (p == BC) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    cur_valid = 1'b0;
                    $display("FAIL scoreboard_underflow @%0t: actual empty required entry", $time);
                end else begin
                    cur = q.pop_front();
                    cur_valid = 1'b1;
                end
            end
            if (p < BC) begin
                chk("an_gap", 32'(bus.an), 32'h F);
            end else if (cur_valid) begin
                chk("an_drive", 32'(bus.an), 32'(cur.an));
                if (!cur.sup) begin
                    chk("seg", 32'(bus.seg), 32'(cur.seg));
                    chk("dp", 32'(bus.dp), 32'(cur.dp));
                end
            end
        end
    end

    // Anode hygiene: never multi-low; every new low anode follows >= BC all-high cycles
    always @(negedge clk) begin
        if (!rst) begin
            chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
            if (bus.an != 4'hF && bus.an != prev_an) begin
                chk("an_gap_before_switch", 32'(prev_an == 4'hF && hi_run >= BC), 32'd1);
            end
        end
        if (bus.an == 4'hF) hi_run++;
        else                hi_run = 0;
        prev_an = bus.an;
    end

    // Called at the negedge that starts a slot; runs exactly one slot.
    task automatic run_slot(input logic [19:0] dg, input logic [3:0] dpm, input logic adj_v,
                            input logic [3:0] bm, input bit sup,
                            input bit mid_en, input logic [19:0] mid_dg);
        rec_t r;
        int i;
        logic [4:0] code;
        i = slot_idx % ND;
        bus.digits     = dg;
        bus.dp_mask    = dpm;
        bus.adj        = adj_v;
        bus.blink_mask = bm;
        code  = dg[5*i +: 5];
        r.sup = sup;
        r.an  = 4'hF;
        if (!sup) r.an[i] = 1'b0;
        r.seg = glyph(code);
        r.dp  = ~dpm[i];
        q.push_back(r);
        if (mid_en) begin
            repeat (4) @(negedge clk);
            bus.digits = mid_dg;
            repeat (RD - 4) @(negedge clk);
        end else begin
            repeat (RD) @(negedge clk);
        end
        slot_idx++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] d_basic, d_c, d_20, d_m1, d_m2, dg;
        logic [3:0]  dpm;
        logic [15:0] sup_tbl;
        d_basic = {5'd3, 5'd2, 5'd1, 5'd0};
        d_c     = {5'd3, 5'd2, 5'd12, 5'd0};
        d_20    = {5'd3, 5'd2, 5'd20, 5'd0};
        d_m1    = {5'd3, 5'd5, 5'd1, 5'd0};
        d_m2    = {5'd3, 5'd7, 5'd1, 5'd0};
        // blink slots relative to adj rise: 4,5 (digits 0/1, off phase), 12 (digit 0)
        sup_tbl = 16'h1030;

        bus.digits = '0;
        bus.dp_mask = '0;
        bus.adj = 1'b0;
        bus.blink_mask = '0;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_an", 32'(bus.an), 32'hF);
        chk("reset_seg", 32'(bus.seg), 32'h7F);
        chk("reset_dp", 32'(bus.dp), 32'd1);
        rst = 1'b0;
        slot_idx = 0;
        mon_en = 1'b1;

        // Basic scan, two frames
        for (int s = 0; s < 8; s++) run_slot(d_basic, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, '0);

        // Decode range and decimal point
        for (int s = 0; s < 4; s++) run_slot(d_c, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, '0);
        for (int s = 0; s < 4; s++) run_slot(d_20, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, '0);

        // Random digits, slot-aligned changes
        for (int s = 0; s < 124; s++) begin
            for (int k = 0; k < ND; k++) dg[5*k +: 5] = 5'($urandom_range(31, 0));
            dpm = 4'($urandom_range(15, 0));
            run_slot(dg, dpm, 1'b0, 4'($urandom_range(15, 0)), 1'b0, 1'b0, '0);
        end

        // Blink: adj rises at a frame start, drops at relative slot 13
        for (int r = 0; r < 16; r++) begin
            run_slot(d_basic, 4'b0000, (r < 13) ? 1'b1 : 1'b0, 4'b0011, sup_tbl[r], 1'b0, '0);
        end

        // Mid-slot change of digit 2 (5 -> 7 at cnt=4)
        run_slot(d_m1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, '0);
        run_slot(d_m1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, '0);
        run_slot(d_m1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, d_m2);
        for (int s = 0; s < 5; s++) run_slot(d_m2, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, '0);

        // Asynchronous reset in the middle of digit 0's drive window
        mon_en = 1'b0;
        bus.digits = d_basic;
        repeat (4) @(negedge clk);
        chk("pre_reset_an", 32'(bus.an), 32'hE);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_an", 32'(bus.an), 32'hF);
        chk("async_reset_seg", 32'(bus.seg), 32'h7F);
        chk("async_reset_dp", 32'(bus.dp), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        cur_valid = 1'b0;
        slot_idx = 0;
        mon_en = 1'b1;
        for (int s = 0; s < 4; s++) run_slot(d_basic, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, '0);
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
